// File: rtl/csr_block.sv
// -----------------------------------------------------------------------------
// csr_block -- APB control/status register block
//
// Purpose: a small APB3 slave holding a control register, a live status view,
// a sticky W1C interrupt status with enables, a scratch register and an event
// counter. The access phase is stretched by WAIT_STATES cycles before pready.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-high reset
//   psel, penable, pwrite    APB control
//   paddr[7:0], pwdata[31:0] APB byte address and write data
//   prdata[31:0]             read data (zero unless a good read completes)
//   pready, pslverr          transfer done / error (misaligned or unmapped)
//   status_in[31:0]          live status, visible at 0x04
//   event_in[7:0]            single-cycle event pulses, one per bit
//   ctrl_out[31:0]           current CTRL value
//   irq                      registered |(INT_STAT & INT_EN)
//
// Map: 0x00 CTRL RW, 0x04 STATUS RO, 0x08 INT_STAT W1C [7:0],
//      0x0C INT_EN RW [7:0], 0x10 SCRATCH RW, 0x14 COUNT RO
// -----------------------------------------------------------------------------
module csr_block #(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] SCRATCH_RST = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [7:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic [31:0] status_in,
   input  logic [7:0]  event_in,
   output logic [31:0] ctrl_out,
   output logic        irq
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;

   logic [31:0] ctrl_q, ctrl_d;
   logic [7:0]  int_stat_q, int_stat_d;
   logic [7:0]  int_en_q, int_en_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] count_q, count_d;
   logic        irq_q, irq_d;

   logic        addr_ok;
   logic        wr_en;
   logic        w1c_en;
   logic [31:0] rdata;
   logic [3:0]  ev_cnt;

   // ---------------------------------------------------------------- FSM ----
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
               cnt_d   = '0;
            end
         end
         ACCESS: begin
            // Dropping psel abandons the transfer; nothing is committed.
            if (!psel || pready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != WAIT_CNT) begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign pready = (state_q == ACCESS) && psel && penable && (cnt_q == WAIT_CNT);

   // ------------------------------------------------------------- decode ----
   assign addr_ok = (paddr[1:0] == 2'b00) && (paddr <= 8'h14);
   assign pslverr = pready && !addr_ok;
   assign wr_en   = pready && pwrite && addr_ok;
   assign w1c_en  = wr_en && (paddr == 8'h08);

   always_comb begin
      rdata = '0;
      case (paddr)
         8'h00:   rdata = ctrl_q;
         8'h04:   rdata = status_in;
         8'h08:   rdata = {24'h0, int_stat_q};
         8'h0C:   rdata = {24'h0, int_en_q};
         8'h10:   rdata = scratch_q;
         8'h14:   rdata = count_q;
         default: rdata = '0;
      endcase
   end

   assign prdata = (pready && !pwrite && addr_ok) ? rdata : '0;

   // ---------------------------------------------------------- registers ----
   assign ctrl_d    = (wr_en && paddr == 8'h00) ? pwdata       : ctrl_q;
   assign int_en_d  = (wr_en && paddr == 8'h0C) ? pwdata[7:0]  : int_en_q;
   assign scratch_d = (wr_en && paddr == 8'h10) ? pwdata       : scratch_q;

   // A new event on a bit wins over a simultaneous W1C of the same bit.
   for (genvar gi = 0; gi < 8; gi++) begin : g_int_stat
      assign int_stat_d[gi] = event_in[gi] | (int_stat_q[gi] & ~(w1c_en & pwdata[gi]));
   end

   always_comb begin
      ev_cnt = '0;
      for (int i = 0; i < 8; i++) begin
         ev_cnt = ev_cnt + {3'b000, event_in[i]};
      end
   end

   // Natural 32-bit wrap of the adder gives the modulo behaviour.
   assign count_d = ctrl_q[0] ? (count_q + {28'h0, ev_cnt}) : count_q;

   assign irq_d = |(int_stat_q & int_en_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ctrl_q     <= '0;
         int_stat_q <= '0;
         int_en_q   <= '0;
         scratch_q  <= SCRATCH_RST;
         count_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ctrl_q     <= ctrl_d;
         int_stat_q <= int_stat_d;
         int_en_q   <= int_en_d;
         scratch_q  <= scratch_d;
         count_q    <= count_d;
         irq_q      <= irq_d;
      end
   end

   assign ctrl_out = ctrl_q;
   assign irq      = irq_q;

endmodule

// File: doc/csr_block.md
CSR_BLOCK -- requirements
Module: csr_block

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning the number of access-phase cycles with pready low before pready is driven high (legal range 0..7).
REQ-002 SHALL have parameter SCRATCH_RST, default 32'hDEAD_BEEF, meaning the reset value of SCRATCH.
REQ-003 SHALL have port clk  input  1  single clock; all flops rise-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port psel  input  1  APB select.
REQ-006 SHALL have port penable  input  1  APB access phase.
REQ-007 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port paddr  input  8  byte address.
REQ-009 SHALL have port pwdata  input  32  write data.
REQ-010 SHALL have port prdata  output  32  read data.
REQ-011 SHALL have port pready  output  1  transfer completes.
REQ-012 SHALL have port pslverr  output  1  error, valid only while pready=1.
REQ-013 SHALL have port status_in  input  32  live status, sampled on read.
REQ-014 SHALL have port event_in  input  8  per-bit single-cycle event pulses.
REQ-015 SHALL have port ctrl_out  output  32  current CTRL value.
REQ-016 SHALL have port irq  output  1  registered interrupt.

Function
REQ-017 SHALL implement this register map: 0x00 CTRL RW; 0x04 STATUS RO (= status_in); 0x08 INT_STAT W1C, bits[7:0] only; 0x0C INT_EN RW, bits[7:0] only; 0x10 SCRATCH RW; 0x14 COUNT RO.
REQ-018 SHALL hold CTRL, INT_STAT, INT_EN, SCRATCH and COUNT in dedicated flops with stable hierarchical names (ctrl_q, int_stat_q, int_en_q, scratch_q, count_q) so testbench backdoor APIs can peek and force them.
REQ-019 SHALL use an FSM with states IDLE and ACCESS: IDLE -> ACCESS when psel=1 and penable=0; ACCESS -> IDLE in the cycle pready=1; ACCESS also -> IDLE if psel drops (abort, no side effects).
REQ-020 SHALL clear a wait counter on entry to ACCESS and increment it each ACCESS cycle; pready = (state==ACCESS) and psel and penable and (cnt==WAIT_STATES), combinationally.
REQ-021 SHALL commit a write only at the clock edge where psel, penable, pwrite and pready are all 1.
REQ-022 SHALL drive prdata with the addressed register value while pready=1 and the access is a read, and drive prdata=0 otherwise.
REQ-023 SHALL assert pslverr with pready for an unmapped address (>0x14) or a misaligned address (paddr[1:0]!=0); the write is dropped and prdata=0.
REQ-024 SHALL ignore writes to STATUS and COUNT without error (pslverr=0).
REQ-025 SHALL set INT_STAT[i] on each cycle event_in[i]=1; a W1C write of 1 clears the bit; when a set and a clear of the same bit occur in the same cycle, the set SHALL win.
REQ-026 SHALL increment COUNT by popcount(event_in) each cycle CTRL[0]=1, modulo 2^32 (wrap 0xFFFF_FFFF + 1 -> 0); COUNT SHALL hold while CTRL[0]=0.
REQ-027 SHALL drive irq as a flop of |(INT_STAT & INT_EN), giving 1 cycle latency from the register update.
REQ-028 SHALL drive ctrl_out directly from ctrl_q.

Reset
REQ-029 SHALL force, while rst=1 and independent of clk: state=IDLE, cnt=0, CTRL=0, INT_STAT=0, INT_EN=0, SCRATCH=SCRATCH_RST, COUNT=0, irq=0.
REQ-030 SHALL hold outputs during reset at pready=0, pslverr=0, prdata=0, ctrl_out=0.
REQ-031 SHALL abandon any transfer in progress when rst asserts mid-access, with no register modified; the first transfer after deassertion SHALL start from IDLE.

Verification
REQ-032 SHALL cover: reset, then read 0x10 -> 0xDEADBEEF, pslverr=0, pready high on the 2nd access cycle (WAIT_STATES=1).
REQ-033 SHALL cover: write 0x10 = 0x1234_5678, then read -> 0x1234_5678; write 0x04 = 0xFFFF_FFFF -> pslverr=0 and STATUS still equals status_in.
REQ-034 SHALL cover: read 0x18 and read 0x02 -> pslverr=1, prdata=0; no register changes.
REQ-035 SHALL cover: INT_EN=0x01, pulse event_in=0x01 -> INT_STAT=0x01 and irq=1 one cycle later; W1C 0x01 in the same cycle as a new pulse -> INT_STAT stays 0x01.
REQ-036 SHALL cover: backdoor force count_q=0xFFFF_FFFF, CTRL=1, event_in=0x03 for one cycle -> COUNT=0x0000_0001.
REQ-037 SHALL cover: rst asserted during the ACCESS wait cycle of a write to 0x00 -> CTRL=0 and pready=0 immediately; after deassertion a new write completes normally.
